// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps at most one imem request in flight and
// hands fetched words with their PCs to the decoder through a 2-entry FIFO.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH        = 32,
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [DATA_WIDTH-1:0]        imem_addr,
  input  logic                         imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
  input  logic                         redirect_valid,
  input  logic [DATA_WIDTH-1:0]        redirect_pc,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic [DATA_WIDTH-1:0]        inst_pc,
  output logic                         fetch_error
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_e;

  state_e                       state_q, state_d;
  logic [DATA_WIDTH-1:0]        pc_q, pc_d;
  logic [DATA_WIDTH-1:0]        inflightPc_q, inflightPc_d;
  logic                         fetchError_q, fetchError_d;
  logic [1:0]                   count_q;
  logic [INSTRUCTION_WIDTH-1:0] headData_q, tailData_q;
  logic [DATA_WIDTH-1:0]        headPc_q, tailPc_q;

  logic       redirectTake;
  logic       misaligned;
  logic       reqFire;
  logic       push;
  logic       pop;
  logic       flush;
  logic [2:0] postCount;

  assign redirectTake = redirect_valid && (state_q != HALT);
  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign reqFire      = (state_q == REQ) && imem_req_ready;
  assign flush        = redirectTake;
  // A pop that coincides with a redirect is void: the entry is flushed instead.
  assign pop          = inst_valid && inst_ready && !redirectTake;
  assign postCount    = {1'b0, count_q} + 3'd1 - {2'b00, pop};

  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = imem_req_valid ? pc_q : '0;
  assign inst_valid     = (count_q != 2'd0);
  assign instructionOut = inst_valid ? headData_q : '0;
  assign inst_pc        = inst_valid ? headPc_q : '0;
  assign fetch_error    = fetchError_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inflightPc_q <= '0;
      fetchError_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflightPc_q <= inflightPc_d;
      fetchError_q <= fetchError_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflightPc_d = inflightPc_q;
    fetchError_d = fetchError_q;
    push         = 1'b0;
    if (redirectTake) begin
      if (misaligned) fetchError_d = 1'b1;
      else            pc_d = redirect_pc;
      // A misaligned target halts, but only once no response is still owed to us.
      case (state_q)
        IDLE: begin
          if (misaligned)                      state_d = HALT;
          else if (enable && count_q < 2'd2)   state_d = REQ;
        end
        REQ: begin
          if (reqFire)         state_d = DROP;
          else if (misaligned) state_d = HALT;
        end
        WAIT: begin
          if (!imem_resp_valid) state_d = DROP;
          else if (misaligned)  state_d = HALT;
          else                  state_d = REQ;
        end
        DROP: begin
          if (imem_resp_valid) begin
            if (misaligned || fetchError_q) state_d = HALT;
            else                            state_d = enable ? REQ : IDLE;
          end
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        IDLE: if (enable && count_q < 2'd2) state_d = REQ;
        REQ: begin
          if (reqFire) begin
            inflightPc_d = pc_q;
            pc_d         = pc_q + DATA_WIDTH'(4);
            state_d      = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            push    = 1'b1;
            state_d = (enable && postCount < 3'd2) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (imem_resp_valid) state_d = fetchError_q ? HALT : (enable ? REQ : IDLE);
        end
        default: ;
      endcase
    end
  end

  // Two-entry FIFO with a registered head; space was reserved at issue so push never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      headData_q <= '0;
      tailData_q <= '0;
      headPc_q   <= '0;
      tailPc_q   <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            headData_q <= imem_resp_data;
            headPc_q   <= inflightPc_q;
          end else begin
            tailData_q <= imem_resp_data;
            tailPc_q   <= inflightPc_q;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          headData_q <= tailData_q;
          headPc_q   <= tailPc_q;
          count_q    <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            headData_q <= imem_resp_data;
            headPc_q   <= inflightPc_q;
          end else begin
            headData_q <= tailData_q;
            headPc_q   <= tailPc_q;
            tailData_q <= imem_resp_data;
            tailPc_q   <= inflightPc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a memory model with random timing feeds the DUT, and a
// scoreboard expects the decoder to see the sequential program stream from the last redirect.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instructionOut;
  logic [31:0] inst_pc;
  logic        fetch_error;

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          popCount = 0;
  logic [31:0] expQ[$];
  logic [31:0] hsQ[$];
  int          hsCycle[$];

  logic        forceReady = 1'b1;
  int          fixedDelay = 0;
  logic        memPending = 1'b0;
  logic [31:0] memAddr = '0;
  int          memDelay = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instructionOut (instructionOut),
    .inst_pc        (inst_pc),
    .fetch_error    (fetch_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0:   w = 32'h0010_0093;
      32'h4:   w = 32'h0020_0113;
      32'h8:   w = 32'h0030_0193;
      default: w = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic fillStream(input logic [31:0] start);
    expQ.delete();
    for (int i = 0; i < 256; i++) expQ.push_back(start + 32'(4 * i));
  endtask

  // Drive one redirect cycle; the expected program stream restarts at an aligned target.
  task automatic applyStimulus(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    expQ.delete();
    if (target[1:0] == 2'b00) fillStream(target);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    expQ.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    hsQ.delete();
    hsCycle.delete();
    fillStream(32'h0);
  endtask

  task automatic expectHs(input int idx, input logic [31:0] addr, input string name);
    int b = 0;
    while (hsQ.size() <= idx && b < 80) begin
      tick();
      b++;
    end
    if (hsQ.size() <= idx) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout handshakes=%0d required=%0d", name, hsQ.size(), idx + 1);
    end else begin
      checkOutput(name, hsQ[idx], addr);
    end
  endtask

  // Instruction memory: samples handshakes away from the edge, answers after a delay.
  initial begin
    logic        hs;
    logic [31:0] hsAddr;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      hs     = rst_n && imem_req_valid && imem_req_ready;
      hsAddr = imem_addr;
      if (!rst_n) memPending = 1'b0;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (hs) begin
        memPending = 1'b1;
        memAddr    = hsAddr;
        memDelay   = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
      end
      if (memPending) begin
        if (memDelay == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = memWord(memAddr);
          memPending      = 1'b0;
        end else begin
          memDelay--;
        end
      end
      imem_req_ready = forceReady ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: records handshakes and scores every instruction the decoder consumes.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req_valid && imem_req_ready) begin
          hsQ.push_back(imem_addr);
          hsCycle.push_back(cycle);
          checkOutput("one_outstanding", {31'b0, memPending}, 32'h0);
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          popCount++;
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected actual_pc=0x%08h required=no_instruction", inst_pc);
          end else begin
            e = expQ.pop_front();
            checkOutput("inst_pc", inst_pc, e);
            checkOutput("inst_word", instructionOut, memWord(e));
          end
        end
      end
    end
  end

  initial begin
    int n;
    int reqSeen;
    int found;
    int startPops;
    int sinceRedirect;
    rst_n          = 1'b0;
    enable         = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();

    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("rst_inst_word", instructionOut, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_fetch_error", {31'b0, fetch_error}, 32'h0);

    // Straight-line fetch with a ready single-cycle memory.
    rst_n = 1'b1;
    fillStream(32'h0);
    tick();
    enable = 1'b1;
    tick();
    checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
    checkOutput("first_req_addr", imem_addr, 32'h0);
    expectHs(0, 32'h0, "req_addr0");
    expectHs(1, 32'h4, "req_addr1");
    expectHs(2, 32'h8, "req_addr2");
    if (hsCycle.size() >= 3) begin
      checkOutput("req_spacing01", 32'(hsCycle[1] - hsCycle[0]), 32'd2);
      checkOutput("req_spacing12", 32'(hsCycle[2] - hsCycle[1]), 32'd2);
    end
    repeat (6) tick();

    // Decoder backpressure: the buffer fills to two and fetching stops.
    inst_ready = 1'b0;
    resetDut();
    repeat (12) tick();
    checkOutput("bp_handshakes", 32'(hsQ.size()), 32'd2);
    checkOutput("bp_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("bp_inst_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("bp_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    expectHs(2, 32'h8, "bp_resume_addr");
    repeat (6) tick();

    // Redirect while waiting on a slow response.
    fixedDelay = 3;
    n = hsQ.size();
    found = 0;
    for (int b = 0; b < 20 && found == 0; b++) begin
      tick();
      if (hsQ.size() > n) found = 1;
    end
    if (found == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_redirect_setup timeout handshakes=%0d required=%0d", hsQ.size(), n + 1);
    end
    applyStimulus(32'h40);
    fixedDelay = 0;
    checkOutput("drop_no_req", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("drop_inst_valid", {31'b0, inst_valid}, 32'h0);
    n = hsQ.size();
    expectHs(n, 32'h40, "wait_redirect_addr");
    repeat (6) tick();

    // Redirect on the very cycle a request at 0x8 is accepted.
    resetDut();
    found = 0;
    for (int b = 0; b < 30 && found == 0; b++) begin
      if (imem_req_valid && imem_addr == 32'h8) found = 1;
      else tick();
    end
    if (found == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL req8_setup timeout addr=0x%08h required=0x00000008", imem_addr);
    end
    applyStimulus(32'h80);
    n = hsQ.size();
    if (n > 0) checkOutput("hs_at_redirect", hsQ[n-1], 32'h8);
    expectHs(n, 32'h80, "req_redirect_addr");
    repeat (6) tick();

    // Misaligned redirect halts the unit until reset.
    applyStimulus(32'h42);
    repeat (6) tick();
    checkOutput("halt_fetch_error", {31'b0, fetch_error}, 32'h1);
    checkOutput("halt_inst_valid", {31'b0, inst_valid}, 32'h0);
    n = hsQ.size();
    reqSeen = 0;
    repeat (20) begin
      tick();
      if (imem_req_valid) reqSeen++;
    end
    checkOutput("halt_no_req", 32'(reqSeen), 32'h0);
    checkOutput("halt_hs_count", 32'(hsQ.size()), 32'(n));
    rst_n = 1'b0;
    #1;
    checkOutput("halt_reset_clears", {31'b0, fetch_error}, 32'h0);
    expQ.delete();
    tick();
    tick();
    rst_n = 1'b1;
    hsQ.delete();
    hsCycle.delete();
    fillStream(32'h0);
    expectHs(0, 32'h0, "restart_pc");
    repeat (6) tick();

    // Address wrap at the top of the space.
    applyStimulus(32'hFFFF_FFFC);
    n = hsQ.size();
    expectHs(n, 32'hFFFF_FFFC, "wrap_addr_top");
    expectHs(n + 1, 32'h0, "wrap_addr_zero");
    repeat (8) tick();

    // Random memory/decoder timing with aligned redirects and occasional resets.
    forceReady    = 1'b0;
    fixedDelay    = -1;
    sinceRedirect = 0;
    startPops     = popCount;
    for (int c = 0; c < 2500; c++) begin
      enable     = ($urandom_range(0, 9) != 0);
      inst_ready = ($urandom_range(0, 9) < 7);
      if (c == 900 || c == 1700) begin
        resetDut();
        sinceRedirect = 0;
      end else if (sinceRedirect >= 100 || $urandom_range(0, 39) == 0) begin
        applyStimulus($urandom() & 32'hFFFF_FFFC);
        sinceRedirect = 0;
      end else begin
        tick();
        sinceRedirect++;
      end
    end
    enable     = 1'b0;
    inst_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (popCount - startPops < 100) begin
      failures++;
      $display("[TB] FAIL random_progress actual_pops=%0d required_min=100", popCount - startPops);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
